// File: rtl/axis_eth_frame_gen_64_pkg.sv
// Shared definitions for the 64-bit AXI-Stream Ethernet frame generator:
// header geometry, beat width, FSM states and the last-beat keep helper.
package axis_eth_frame_gen_64_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned ETH_MAC_W   = 48;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned KEEP_W      = DATA_W / 8;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // rem is the number of frame bytes left at the start of the beat (>= 1).
    function automatic logic [KEEP_W-1:0] keep_for_rem(input logic [15:0] rem);
        logic [KEEP_W-1:0] keep;
        if (rem >= 16'(KEEP_W)) begin
            keep = {KEEP_W{1'b1}};
        end else begin
            keep = {KEEP_W{1'b1}} >> (4'(KEEP_W) - rem[3:0]);
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_eth_frame_gen_64_if.sv
// 64-bit AXI-Stream bundle carrying generated frames from the generator to
// the MAC transmit FIFO.
interface axis_eth_frame_gen_64_if;
    import axis_eth_frame_gen_64_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_eth_frame_gen_64.sv
// Test frame source: on start, emits a burst of back-to-back Ethernet frames
// (MAC header + incrementing payload, no preamble/FCS) on a 64-bit AXI-Stream.
module axis_eth_frame_gen_64
    import axis_eth_frame_gen_64_pkg::*;
#(
    parameter logic [ETH_MAC_W-1:0] DEST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [ETH_MAC_W-1:0] SRC_MAC     = 48'h0200_0000_0000,
    parameter logic [15:0]          ETHERTYPE   = 16'h88B5,
    parameter int unsigned          MAX_PAYLOAD = 1500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [15:0]             payload_len,
    input  logic [7:0]              seed,
    input  logic [7:0]              frame_count,
    axis_eth_frame_gen_64_if.master output_axis,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frames_sent
);

    // Header laid out in wire order: byte 0 sits in the top 8 bits.
    localparam logic [8*ETH_HDR_LEN-1:0] HDR_WIRE = {DEST_MAC, SRC_MAC, ETHERTYPE};

    function automatic logic [15:0] clamp_len(input logic [15:0] n);
        return (32'(n) > MAX_PAYLOAD) ? 16'(MAX_PAYLOAD) : n;
    endfunction

    // Byte at frame offset pos; lanes past the end of the frame read as zero.
    function automatic logic [7:0] lane_byte(input logic [15:0] pos, input logic [15:0] len,
                                             input logic [7:0] fseed);
        logic [3:0]  idx;
        logic [15:0] j;
        logic [7:0]  b;
        idx = 4'(ETH_HDR_LEN - 1) - pos[3:0];
        j   = pos - 16'(ETH_HDR_LEN);
        if (pos >= len) begin
            b = 8'h00;
        end else if (pos < 16'(ETH_HDR_LEN)) begin
            b = HDR_WIRE[{idx, 3'b000} +: 8];
        end else begin
            b = fseed + j[7:0];
        end
        return b;
    endfunction

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        fseed_q, fseed_d;
    logic [7:0]        left_q, left_d;
    logic [15:0]       off_q, off_d;
    logic              more_q, more_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              done_q, done_d;
    logic [15:0]       sent_q, sent_d;

    logic              hs;
    logic              load;
    logic [15:0]       cur_len;
    logic [7:0]        cur_seed;
    logic [15:0]       cur_off;
    logic [7:0]        cur_left;
    logic [DATA_W-1:0] beat_data;
    logic [KEEP_W-1:0] beat_keep;
    logic              beat_last;

    assign hs = tvalid_q & output_axis.tready;

    // In IDLE the beat cursor comes straight from the start inputs so beat 0
    // is registered on the same edge that accepts start.
    always_comb begin
        cur_len  = len_q;
        cur_seed = fseed_q;
        cur_off  = off_q;
        cur_left = left_q;
        load     = 1'b0;
        if (state_q == StIdle) begin
            cur_len  = 16'(ETH_HDR_LEN) + clamp_len(payload_len);
            cur_seed = seed;
            cur_off  = '0;
            cur_left = (frame_count == 8'd0) ? 8'd0 : frame_count - 8'd1;
            load     = start;
        end else begin
            load = more_q & (~tvalid_q | output_axis.tready);
        end
    end

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            beat_data[8*k +: 8] = lane_byte(cur_off + 16'(k), cur_len, cur_seed);
        end
        beat_last = (cur_off + 16'(KEEP_W)) >= cur_len;
        beat_keep = beat_last ? keep_for_rem(cur_len - cur_off) : {KEEP_W{1'b1}};
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        fseed_d  = fseed_q;
        left_d   = left_q;
        off_d    = off_q;
        more_d   = more_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        sent_d   = sent_q;

        if (hs && tlast_q) begin
            sent_d = sent_q + 16'd1;
        end
        if (hs && !load) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
        end
        if (hs && tlast_q && !more_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
        end

        if (load) begin
            state_d  = StSend;
            tdata_d  = beat_data;
            tkeep_d  = beat_keep;
            tlast_d  = beat_last;
            tvalid_d = 1'b1;
            len_d    = cur_len;
            fseed_d  = cur_seed;
            left_d   = cur_left;
            if (!beat_last) begin
                off_d  = cur_off + 16'(KEEP_W);
                more_d = 1'b1;
            end else if (cur_left != 8'd0) begin
                off_d   = '0;
                fseed_d = cur_seed + 8'd1;
                left_d  = cur_left - 8'd1;
                more_d  = 1'b1;
            end else begin
                more_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            len_q    <= '0;
            fseed_q  <= '0;
            left_q   <= '0;
            off_q    <= '0;
            more_q   <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            fseed_q  <= fseed_d;
            left_q   <= left_d;
            off_q    <= off_d;
            more_q   <= more_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
        end
    end

    assign output_axis.tdata  = tdata_q;
    assign output_axis.tkeep  = tkeep_q;
    assign output_axis.tvalid = tvalid_q;
    assign output_axis.tlast  = tlast_q;
    assign output_axis.tuser  = 1'b0;
    assign busy               = (state_q == StSend);
    assign done               = done_q;
    assign frames_sent        = sent_q;

endmodule

// File: tb/tb_axis_eth_frame_gen_64.sv
// Self-checking bench for axis_eth_frame_gen_64: a byte-level frame model fills
// a scoreboard queue that is drained as beats handshake on the stream.
module tb_axis_eth_frame_gen_64;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] payload_len;
    logic [7:0]  seed;
    logic [7:0]  frame_count;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;

    int          checks = 0;
    int          errors = 0;
    exp_beat_t   exp_q[$];
    logic [15:0] exp_sent = 16'd0;

    axis_eth_frame_gen_64_if axis ();

    axis_eth_frame_gen_64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .payload_len (payload_len),
        .seed        (seed),
        .frame_count (frame_count),
        .output_axis (axis),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Byte-accurate model of one burst, pushed as expected beats.
    task automatic push_frames(input int len, input logic [7:0] s, input int count);
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [15:0] etype;
        logic [7:0]  bytes[$];
        exp_beat_t   e;
        int          plen;
        int          l;
        int          n;
        dmac  = 48'hFFFF_FFFF_FFFF;
        smac  = 48'h0200_0000_0000;
        etype = 16'h88B5;
        plen  = (len > 1500) ? 1500 : len;
        l     = 14 + plen;
        n     = (count == 0) ? 1 : count;
        for (int f = 0; f < n; f++) begin
            bytes.delete();
            for (int i = 0; i < 6; i++) bytes.push_back(dmac[47-8*i -: 8]);
            for (int i = 0; i < 6; i++) bytes.push_back(smac[47-8*i -: 8]);
            bytes.push_back(etype[15:8]);
            bytes.push_back(etype[7:0]);
            for (int j = 0; j < plen; j++) bytes.push_back(8'(int'(s) + f + j));
            for (int b = 0; b < l; b += 8) begin
                e.data = '0;
                e.keep = '0;
                for (int k = 0; k < 8; k++) begin
                    if (b + k < l) begin
                        e.data[8*k +: 8] = bytes[b+k];
                        e.keep[k]        = 1'b1;
                    end
                end
                e.last = (b + 8 >= l);
                exp_q.push_back(e);
            end
            exp_sent = exp_sent + 16'd1;
        end
    endtask

    task automatic kick(input int len, input logic [7:0] s, input logic [7:0] cnt);
        payload_len = 16'(len);
        seed        = s;
        frame_count = cnt;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        payload_len = '0;
        seed = '0;
        frame_count = '0;
        axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tdata !== 64'h0 ||
            axis.tkeep !== 8'h0 || busy !== 1'b0 || done !== 1'b0 || frames_sent !== 16'h0 ||
            axis.tuser !== 1'b0)
            $display("FAIL reset_state: got valid=%b last=%b data=%h keep=%h busy=%b done=%b sent=%0d, want all zero",
                     axis.tvalid, axis.tlast, axis.tdata, axis.tkeep, busy, done, frames_sent);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        exp_beat_t e;
        int cyc, pops, dones;
        logic d1, d2;
        for (int t = 0; t < 2; t++) begin
            axis.tready = 1'b1;
            push_frames((t == 0) ? 46 : 2, (t == 0) ? 8'h00 : 8'h10, 1);
            kick((t == 0) ? 46 : 2, (t == 0) ? 8'h00 : 8'h10, 8'd1);
            cyc = 0; pops = 0; dones = 0;
            @(negedge clk);
            checks++;
            if (axis.tvalid !== 1'b1 || busy !== 1'b1)
                $display("FAIL start_latency: valid=%b busy=%b, want 1 1", axis.tvalid, busy);
            while ((exp_q.size() != 0 || busy) && cyc < 400) begin
                if (axis.tvalid && axis.tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL single_extra_beat: data=%h, want no beat", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                            errors++;
                            $display("FAIL single_beat%0d: got %h/%h/%b want %h/%h/%b", pops,
                                     axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                        end
                    end
                    checks++;
                    if (t == 0 && pops == 0 && (axis.tdata !== 64'h0002FFFFFFFFFFFF || axis.tkeep !== 8'hFF)) begin
                        errors++;
                        $display("FAIL len46_beat0: got %h/%h want 0002ffffffffffff/ff", axis.tdata, axis.tkeep);
                    end
                    if (t == 0 && pops == 7 && (axis.tkeep !== 8'h0F || axis.tlast !== 1'b1)) begin
                        errors++;
                        $display("FAIL len46_beat7: got keep=%h last=%b want 0f 1", axis.tkeep, axis.tlast);
                    end
                    if (t == 1 && pops == 1 && (axis.tdata !== 64'h1110B58800000000 ||
                                                axis.tkeep !== 8'hFF || axis.tlast !== 1'b1)) begin
                        errors++;
                        $display("FAIL len2_beat1: got %h/%h/%b want 1110b58800000000/ff/1",
                                 axis.tdata, axis.tkeep, axis.tlast);
                    end
                    pops++;
                end
                if (done) dones++;
                @(posedge clk);
                #1;
                cyc++;
                @(negedge clk);
            end
            d1 = done;
            @(negedge clk);
            d2 = done;
            checks++;
            if (cyc >= 400 || pops != ((t == 0) ? 8 : 2) || dones != 0 || d1 !== 1'b1 || d2 !== 1'b0) begin
                errors++;
                $display("FAIL single_end%0d: beats=%0d cyc=%0d done=%0d,%b,%b want beats=%0d done 0,1,0",
                         t, pops, cyc, dones, d1, d2, (t == 0) ? 8 : 2);
            end
            checks++;
            if (frames_sent !== exp_sent) begin
                errors++;
                $display("FAIL single_frames_sent: got %0d want %0d", frames_sent, exp_sent);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        exp_beat_t e;
        int cyc, pops, drops;
        logic stalled;
        logic [63:0] pd;
        logic [7:0] pk;
        logic pl;
        push_frames(100, 8'h5A, 1);
        axis.tready = 1'b0;
        kick(100, 8'h5A, 8'd1);
        cyc = 0; pops = 0; drops = 0; stalled = 1'b0; pd = '0; pk = '0; pl = 1'b0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && cyc < 1000) begin
            if (stalled) begin
                checks++;
                if (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tkeep !== pk || axis.tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: got %b %h/%h/%b want 1 %h/%h/%b", axis.tvalid,
                             axis.tdata, axis.tkeep, axis.tlast, pd, pk, pl);
                end
            end
            if (busy && !axis.tvalid) drops++;
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra_beat: data=%h, want no beat", axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                        errors++;
                        $display("FAIL stall_beat%0d: got %h/%h/%b want %h/%h/%b", pops,
                                 axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                    end
                end
                pops++;
            end
            stalled = axis.tvalid && !axis.tready;
            pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
            @(posedge clk);
            #1;
            axis.tready = ($urandom_range(0, 1) == 1);
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc >= 1000 || pops != 15 || drops != 0) begin
            errors++;
            $display("FAIL stall_end: beats=%0d drops=%0d cyc=%0d want beats=15 drops=0", pops, drops, cyc);
        end
        axis.tready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_beat_t e;
        int cyc, pops, gaps, dones;
        logic d1, d2;
        push_frames(1, 8'hFE, 3);
        axis.tready = 1'b1;
        kick(1, 8'hFE, 8'd3);
        cyc = 0; pops = 0; gaps = 0; dones = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            if (busy && !axis.tvalid) gaps++;
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_beat: data=%h, want no beat", axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                        errors++;
                        $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b", pops,
                                 axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                    end
                end
                pops++;
            end
            if (done) dones++;
            @(posedge clk);
            #1;
            cyc++;
            @(negedge clk);
        end
        d1 = done;
        @(negedge clk);
        d2 = done;
        checks++;
        if (cyc >= 200 || pops != 6 || gaps != 0 || dones != 0 || d1 !== 1'b1 || d2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: beats=%0d gaps=%0d done=%0d,%b,%b want beats=6 gaps=0 done 0,1,0",
                     pops, gaps, dones, d1, d2);
        end
        checks++;
        if (frames_sent !== exp_sent) begin
            errors++;
            $display("FAIL b2b_frames_sent: got %0d want %0d", frames_sent, exp_sent);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lengths();
        exp_beat_t e;
        int cyc, pops;
        logic [7:0] last_keep;
        for (int t = 0; t < 2; t++) begin
            push_frames((t == 0) ? 2000 : 0, 8'h33, 1);
            axis.tready = 1'b1;
            kick((t == 0) ? 2000 : 0, 8'h33, 8'd0);
            cyc = 0; pops = 0; last_keep = '0;
            @(negedge clk);
            while ((exp_q.size() != 0 || busy) && cyc < 1000) begin
                if (axis.tvalid && axis.tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL len_extra_beat: data=%h, want no beat", axis.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                            errors++;
                            $display("FAIL len%0d_beat%0d: got %h/%h/%b want %h/%h/%b", t, pops,
                                     axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                        end
                    end
                    last_keep = axis.tkeep;
                    pops++;
                end
                @(posedge clk);
                #1;
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (cyc >= 1000 || pops != ((t == 0) ? 190 : 2) || last_keep !== ((t == 0) ? 8'h03 : 8'h3F)) begin
                errors++;
                $display("FAIL len_end%0d: beats=%0d last_keep=%h want %0d/%h", t, pops, last_keep,
                         (t == 0) ? 190 : 2, (t == 0) ? 8'h03 : 8'h3F);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_start();
        exp_beat_t e;
        int cyc, pops, extra;
        push_frames(10, 8'h20, 2);
        axis.tready = 1'b1;
        kick(10, 8'h20, 8'd2);
        cyc = 0; pops = 0; extra = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_extra_beat: data=%h, want no beat", axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                        errors++;
                        $display("FAIL busy_beat%0d: got %h/%h/%b want %h/%h/%b", pops,
                                 axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                    end
                end
                pops++;
            end
            @(posedge clk);
            #1;
            start       = (cyc == 1);
            payload_len = 16'd300;
            seed        = 8'h99;
            frame_count = 8'd5;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (axis.tvalid) extra++;
        end
        checks++;
        if (cyc >= 200 || pops != 6 || extra != 0 || frames_sent !== exp_sent) begin
            errors++;
            $display("FAIL busy_start_ignored: beats=%0d extra=%0d sent=%0d want 6/0/%0d",
                     pops, extra, frames_sent, exp_sent);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        exp_beat_t e;
        int cyc, pops;
        push_frames(46, 8'h00, 1);
        axis.tready = 1'b1;
        kick(46, 8'h00, 8'd1);
        pops = 0;
        cyc = 0;
        while (pops < 3 && cyc < 50) begin
            @(negedge clk);
            if (axis.tvalid && axis.tready) pops++;
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (axis.tvalid !== 1'b1 || frames_sent == 16'd0) begin
            errors++;
            $display("FAIL pre_reset: valid=%b sent=%0d want 1 and nonzero", axis.tvalid, frames_sent);
        end
        @(negedge clk);
        checks++;
        if (axis.tvalid !== 1'b0 || frames_sent !== 16'd0 || busy !== 1'b0 || axis.tlast !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b sent=%0d busy=%b last=%b want 0 0 0 0",
                     axis.tvalid, frames_sent, busy, axis.tlast);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_sent = 16'd0;
        @(posedge clk);
        #1;
        push_frames(46, 8'hC3, 1);
        kick(46, 8'hC3, 8'd1);
        cyc = 0; pops = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            if (axis.tvalid && axis.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL post_reset_extra_beat: data=%h, want no beat", axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (axis.tdata !== e.data || axis.tkeep !== e.keep || axis.tlast !== e.last) begin
                        errors++;
                        $display("FAIL post_reset_beat%0d: got %h/%h/%b want %h/%h/%b", pops,
                                 axis.tdata, axis.tkeep, axis.tlast, e.data, e.keep, e.last);
                    end
                end
                pops++;
            end
            @(posedge clk);
            #1;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc >= 200 || pops != 8 || frames_sent !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_end: beats=%0d sent=%0d want 8 1", pops, frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_lengths();
        test_busy_start();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
